instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front-end stage directly upstream of instruction_decoder.
- Owns the program counter and issues word requests to instruction memory through a req/ack handshake.
- Buffers returned words in a 2-entry queue and presents instr/pc with a valid flag to the decoder.
- Handles decoder back-pressure (decode_stall) and control-flow redirects, discarding wrong-path fetches.

Parameters:
- PC_WIDTH, 8, width of PC, imem_addr and pc_out.
- RESET_PC, 0, PC value loaded on reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h00000013, word driven on instr_out when the queue is empty (ADDI x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_WIDTH  fetch byte address, word aligned.
- imem_ack  input  1  response valid; may assert in the same cycle as imem_req or any later cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- redirect  input  1  one-cycle pulse: branch/jump taken.
- redirect_pc  input  PC_WIDTH  new fetch target; bits [1:0] ignored and forced to 0.
- decode_stall  input  1  decoder cannot accept this cycle.
- instr_valid  output  1  instr_out/pc_out hold a real instruction.
- instr_out  output  32  instruction to decoder (queue head).
- pc_out  output  PC_WIDTH  address of instr_out.

Behaviour:
Internal state:
- fetch_pc register.
- 2-entry FIFO of {instr, pc} with count 0..2.
- FSM with states FETCH and DRAIN.

Reset (rst=1 at a rising edge):
- fetch_pc=RESET_PC, count=0, FSM=FETCH.
- imem_req=0, instr_valid=0, instr_out=NOP_INSTR, pc_out=0.
- Reset mid-request abandons it: imem_req drops the next cycle, and any later ack is ignored because imem_req=0.

Outputs:
- instr_valid = (count!=0).
- instr_out/pc_out = head entry; NOP_INSTR/0 when count=0.
- pop = instr_valid & ~decode_stall.
- While stalled, head is held stable.

FETCH:
- imem_req=1 with imem_addr=fetch_pc whenever count<2, or count=2 with pop this cycle.
- Once asserted, imem_req and imem_addr stay stable until imem_ack. There is at most 1 outstanding request.
- On imem_ack with no redirect: push {imem_rdata, fetch_pc}; fetch_pc <= fetch_pc+4, modulo 2^PC_WIDTH (0xFC wraps to 0x00 at PC_WIDTH=8).
- Push and pop in the same cycle: count unchanged. A push can never occur at count=2 without a pop.
- Zero-wait memory sustains 1 instruction/cycle, so first instr_valid rises 1 cycle after the first req+ack.

Redirect (highest priority):
- Queue flushed (count<=0, so instr_valid=0 next cycle); fetch_pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}.
- Any pop that cycle is irrelevant.
- Ack in the same cycle: data discarded, FSM stays FETCH, and the new target is requested next cycle.
- Request outstanding without ack: FSM goes to DRAIN.
- No request outstanding: stays FETCH.

DRAIN:
- imem_req held at 1 with the old address.
- On imem_ack: data dropped, then FETCH.
- A second redirect in DRAIN updates fetch_pc only; the FSM stays in DRAIN.

Test Plan:
1. Reset, then zero-wait memory returning word addr*16 -> imem_addr 0,4,8 on consecutive cycles; instr_valid=1 from cycle 2; pc_out 0,4,8 with matching instr_out.
2. decode_stall=1 for 4 cycles after the first instruction, zero-wait memory -> count reaches 2, imem_req=0, pc_out holds 0. On release, pc_out 0,4,8 with no loss or duplicates.
3. Memory with 3-cycle ack latency -> imem_addr stable for 3 cycles; instr_valid pulses once per 3-cycle transaction; pc_out 0,4,8.
4. redirect=1, redirect_pc=0x42 while a 3-cycle request to 0x08 is pending -> DRAIN; the 0x08 data never appears. Next request addresses 0x40; pc_out=0x40 is the first valid after the redirect.
5. redirect coincident with ack of 0x10, with 2 queued entries -> instr_valid=0 next cycle; 0x10 data dropped; next imem_addr=redirect target.
6. Start at 0xF8 via redirect, PC_WIDTH=8 -> pc_out 0xF8, 0xFC, 0x00. rst asserted mid-DRAIN -> next cycle imem_req=0, instr_valid=0, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// over req/ack, and feeds a 2-entry {instr, pc} queue to the decoder.
module instruction_fetch #(
  parameter int unsigned          PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                decode_stall,
  output logic                instr_valid,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pc_out
);

  localparam int unsigned INSTR_WIDTH = 32;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] drain_addr;
  logic [PC_WIDTH-1:0] redirect_tgt;
  logic                fetch_en;
  entry_t              queue [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;
  logic                pop;
  logic                push;
  logic                req_pending;

  assign redirect_tgt = redirect_pc & {{(PC_WIDTH-2){1'b1}}, 2'b00};
  assign instr_valid  = (count != 2'd0);
  assign pop          = instr_valid & ~decode_stall;
  assign instr_out    = instr_valid ? queue[rd_ptr].instr : NOP_INSTR;
  assign pc_out       = instr_valid ? queue[rd_ptr].pc : '0;
  assign req_pending  = imem_req & ~imem_ack;
  assign push         = (state == FETCH) & imem_req & imem_ack & ~redirect;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next state: a redirect with an unanswered request must wait out the stale ack
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (redirect && req_pending) state_nxt = DRAIN;
      DRAIN: if (imem_ack)                state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Memory request outputs; DRAIN keeps the abandoned address stable until its ack
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    if (fetch_en) begin
      unique case (state)
        FETCH: imem_req = (count != 2'd2) | pop;
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_addr;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  // PC, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      fetch_en   <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      fetch_en <= 1'b1;
      if (redirect) begin
        fetch_pc <= redirect_tgt;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        count    <= 2'd0;
        if (state == FETCH && req_pending) drain_addr <= fetch_pc;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + PC_WIDTH'(4);
          wr_ptr   <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        if (push && !pop)      count <= count + 2'd1;
        else if (pop && !push) count <= count - 2'd1;
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= '{instr: imem_rdata, pc: fetch_pc};
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a per-cycle stream model
// checking the decoder sees a contiguous PC sequence with matching memory words.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [7:0]  RST_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        decode_stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;

  int total = 0;
  int bad = 0;
  int wait_cnt = 0;
  int lat_extra = 0;
  int lat_next = 0;

  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .decode_stall(decode_stall),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [7:0] a);
    return {24'h0, a} * 32'd16;
  endfunction

  // Memory: acks after lat_extra wait cycles, returns addr*16
  assign imem_ack   = imem_req && (wait_cnt >= lat_extra);
  assign imem_rdata = imem_ack ? memw(imem_addr) : 32'hDEADBEEF;
  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [7:0] rpc, input logic st);
    @(posedge clk);
    #1;
    rst = r; redirect = rd; redirect_pc = rpc; decode_stall = st; lat_extra = lat_next;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Stream model: what the decoder must see, independent of queue mechanics
  initial begin
    logic [7:0] exp_pc;
    logic       after_rst, flush_next, pend, prev_rst;
    logic [7:0] paddr;
    exp_pc = RST_PC; after_rst = 1'b0; flush_next = 1'b0;
    pend = 1'b0; prev_rst = 1'b0; paddr = 8'h00;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (after_rst) begin
        chk("m_rst_req", 32'(imem_req), 32'd0);
        chk("m_rst_valid", 32'(instr_valid), 32'd0);
      end
      if (flush_next) chk("m_flush_valid", 32'(instr_valid), 32'd0);
      if (pend && !prev_rst) begin
        chk("m_req_hold", 32'(imem_req), 32'd1);
        chk("m_addr_hold", 32'(imem_addr), 32'(paddr));
      end
      if (imem_req) chk("m_addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (instr_valid) begin
        chk("m_pc_stream", 32'(pc_out), 32'(exp_pc));
        chk("m_instr_word", instr_out, memw(pc_out));
      end else begin
        chk("m_nop_instr", instr_out, NOP);
        chk("m_nop_pc", 32'(pc_out), 32'd0);
      end
      pend = imem_req && !imem_ack;
      paddr = imem_addr;
      prev_rst = rst;
      after_rst = rst;
      flush_next = 1'b0;
      if (rst) exp_pc = RST_PC;
      else if (redirect) begin
        exp_pc = {redirect_pc[7:2], 2'b00};
        flush_next = 1'b1;
      end else if (instr_valid && !decode_stall) exp_pc = exp_pc + 8'd4;
    end
  end

  initial begin
    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", 32'(pc_out), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rel_req", 32'(imem_req), 32'd0);

    // T1: zero-wait streaming
    idle(1);
    chk("t1_c1_req", 32'(imem_req), 32'd1);
    chk("t1_c1_addr", 32'(imem_addr), 32'h00);
    chk("t1_c1_valid", 32'(instr_valid), 32'd0);
    idle(1);
    chk("t1_c2_addr", 32'(imem_addr), 32'h04);
    chk("t1_c2_valid", 32'(instr_valid), 32'd1);
    chk("t1_c2_pc", 32'(pc_out), 32'h00);
    idle(1);
    chk("t1_c3_addr", 32'(imem_addr), 32'h08);
    chk("t1_c3_pc", 32'(pc_out), 32'h04);
    chk("t1_c3_instr", instr_out, 32'h40);
    idle(1);
    chk("t1_c4_pc", 32'(pc_out), 32'h08);
    chk("t1_c4_instr", instr_out, 32'h80);

    // T2: decoder stall fills the queue and blocks requests
    do_reset();
    idle(1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_c2_pc", 32'(pc_out), 32'h00);
    chk("t2_c2_addr", 32'(imem_addr), 32'h04);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t2_full_req", 32'(imem_req), 32'd0);
      chk("t2_full_pc", 32'(pc_out), 32'h00);
    end
    idle(1);
    chk("t2_rel_req", 32'(imem_req), 32'd1);
    chk("t2_rel_addr", 32'(imem_addr), 32'h08);
    chk("t2_rel_pc", 32'(pc_out), 32'h00);
    idle(1);
    chk("t2_pc4", 32'(pc_out), 32'h04);
    idle(1);
    chk("t2_pc8", 32'(pc_out), 32'h08);

    // T3: three-cycle memory latency
    lat_next = 2;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("t3_addr0", 32'(imem_addr), 32'h00);
      chk("t3_wait_valid", 32'(instr_valid), 32'd0);
    end
    idle(1);
    chk("t3_c4_valid", 32'(instr_valid), 32'd1);
    chk("t3_c4_pc", 32'(pc_out), 32'h00);
    chk("t3_c4_addr", 32'(imem_addr), 32'h04);
    idle(1);
    chk("t3_c5_valid", 32'(instr_valid), 32'd0);
    idle(2);
    chk("t3_c7_pc", 32'(pc_out), 32'h04);
    chk("t3_c7_instr", instr_out, 32'h40);
    idle(3);
    chk("t3_c10_pc", 32'(pc_out), 32'h08);

    // T4: redirect while request to 0x08 is pending
    do_reset();
    idle(6);
    step(1'b0, 1'b1, 8'h42, 1'b0);
    chk("t4_c7_addr", 32'(imem_addr), 32'h08);
    chk("t4_c7_pc", 32'(pc_out), 32'h04);
    idle(1);
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    chk("t4_drain_addr", 32'(imem_addr), 32'h08);
    idle(1);
    chk("t4_drain_ack_addr", 32'(imem_addr), 32'h08);
    chk("t4_drain_ack", 32'(imem_ack), 32'd1);
    idle(1);
    chk("t4_new_addr", 32'(imem_addr), 32'h40);
    idle(3);
    chk("t4_new_valid", 32'(instr_valid), 32'd1);
    chk("t4_new_pc", 32'(pc_out), 32'h40);
    chk("t4_new_instr", instr_out, 32'h400);

    // T4b: second redirect while draining only moves the target
    do_reset();
    step(1'b0, 1'b1, 8'h20, 1'b0);
    chk("t4b_c1_addr", 32'(imem_addr), 32'h00);
    step(1'b0, 1'b1, 8'h31, 1'b0);
    chk("t4b_c2_addr", 32'(imem_addr), 32'h00);
    idle(1);
    chk("t4b_c3_addr", 32'(imem_addr), 32'h00);
    idle(1);
    chk("t4b_c4_addr", 32'(imem_addr), 32'h30);
    idle(3);
    chk("t4b_c7_pc", 32'(pc_out), 32'h30);

    // T5: redirect coincident with ack of 0x10, queue full
    lat_next = 0;
    do_reset();
    idle(1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 8'h80, 1'b0);
    chk("t5_addr10", 32'(imem_addr), 32'h10);
    chk("t5_ack", 32'(imem_ack), 32'd1);
    chk("t5_pc8", 32'(pc_out), 32'h08);
    idle(1);
    chk("t5_flush_valid", 32'(instr_valid), 32'd0);
    chk("t5_tgt_addr", 32'(imem_addr), 32'h80);
    idle(1);
    chk("t5_tgt_pc", 32'(pc_out), 32'h80);
    chk("t5_tgt_instr", instr_out, 32'h800);

    // T6: PC wrap, then reset in the middle of DRAIN
    do_reset();
    step(1'b0, 1'b1, 8'hFA, 1'b0);
    chk("t6_c1_addr", 32'(imem_addr), 32'h00);
    idle(1);
    chk("t6_c2_addr", 32'(imem_addr), 32'hF8);
    chk("t6_c2_valid", 32'(instr_valid), 32'd0);
    idle(1);
    chk("t6_pcF8", 32'(pc_out), 32'hF8);
    chk("t6_instrF8", instr_out, 32'hF80);
    idle(1);
    chk("t6_pcFC", 32'(pc_out), 32'hFC);
    chk("t6_wrap_addr", 32'(imem_addr), 32'h00);
    lat_next = 2;
    step(1'b0, 1'b1, 8'h20, 1'b0);
    chk("t6_pc00", 32'(pc_out), 32'h00);
    chk("t6_pend_addr", 32'(imem_addr), 32'h04);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("t6_drain_req", 32'(imem_req), 32'd1);
    chk("t6_drain_addr", 32'(imem_addr), 32'h04);
    idle(1);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    idle(1);
    chk("t6_resume_req", 32'(imem_req), 32'd1);
    chk("t6_resume_addr", 32'(imem_addr), 32'(RST_PC));
    idle(4);
    chk("t6_resume_pc", 32'(pc_out), 32'(RST_PC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
